// File: rtl/dds_dac_spi.sv
// ============================================================================
// Module   : dds_dac_spi
// Brief    : Serialises 8-bit DDS samples MSB-first into 16-bit SPI DAC frames
//            ({CMD, sample, 4'b0}); one sample in flight, valid/ready paced.
//            Optional macro DDS_DAC_SPI_LDAC_EN adds the dac_ldac_n latch strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_dac_spi #(
    parameter int         DIV     = 4,
    parameter int         FRAME_W = 16,
    parameter logic [3:0] CMD     = 4'h3,
    parameter int         CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       busy,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi
`ifdef DDS_DAC_SPI_LDAC_EN
    ,
    output logic       dac_ldac_n
`endif
);

    localparam int c_DW = $clog2(DIV);
    localparam int c_GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);
    localparam logic [3:0]      c_BIT_LAST = 4'(FRAME_W - 1);
    // GAP state covers CS_GAP-1 cycles; the final cs_n-high cycle is the ready IDLE cycle
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_din_rdy;
    logic               r_busy;
    logic               r_cs_n;
    logic               r_sclk;
    logic               r_mosi;
    logic [c_DW-1:0]    r_div_cnt;
    logic [3:0]         r_bit_cnt;
    logic [c_GW-1:0]    r_gap_cnt;
    logic [FRAME_W-1:0] r_shreg;

    logic w_sclk_tick;
    logic w_frame_end;

    assign w_sclk_tick = (r_state == S_SHIFT) && (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_sclk_tick && r_sclk && (r_bit_cnt == c_BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_din_rdy <= 1'b0;
            r_busy    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shreg   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_din_rdy && din_vld) begin
                        r_shreg   <= {CMD, din, 4'b0000};
                        r_mosi    <= CMD[3];
                        r_cs_n    <= 1'b0;
                        r_sclk    <= 1'b0;
                        r_din_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_din_rdy <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_sclk_tick) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (w_frame_end) begin
                            r_cs_n    <= 1'b1;
                            r_mosi    <= 1'b0;
                            r_gap_cnt <= '0;
                            if (CS_GAP == 1) begin
                                r_state   <= S_IDLE;
                                r_busy    <= 1'b0;
                                r_din_rdy <= 1'b1;
                            end else begin
                                r_state   <= S_GAP;
                            end
                        end else if (r_sclk) begin
                            // falling SCLK edge: present the next bit
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_shreg   <= r_shreg << 1;
                            r_mosi    <= r_shreg[FRAME_W-2];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_din_rdy <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign din_rdy  = r_din_rdy;
    assign busy     = r_busy;
    assign dac_cs_n = r_cs_n;
    assign dac_sclk = r_sclk;
    assign dac_mosi = r_mosi;

`ifdef DDS_DAC_SPI_LDAC_EN
    logic r_ldac_n;

    // one-clock low pulse in the first cycle after cs_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ldac_n <= 1'b1;
        end else begin
            r_ldac_n <= ~w_frame_end;
        end
    end

    assign dac_ldac_n = r_ldac_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dds_dac_spi.sv
// ============================================================================
// Module   : tb_dds_dac_spi
// Brief    : Self-checking bench for dds_dac_spi: vector table of samples and
//            expected frames, scoreboard fed at drive time, SPI frame monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_dac_spi;

    localparam int DIV      = 4;
    localparam int CS_GAP   = 2;
    localparam int c_LOW    = 2 * DIV * 16;
    localparam int c_SPACE  = 2 * DIV * 16 + CS_GAP;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic       busy;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_mosi;
`ifdef DDS_DAC_SPI_LDAC_EN
    logic       dac_ldac_n;
`endif

    dds_dac_spi #(
        .DIV     (DIV),
        .FRAME_W (16),
        .CMD     (4'h3),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_vld    (din_vld),
        .din_rdy    (din_rdy),
        .busy       (busy),
        .dac_cs_n   (dac_cs_n),
        .dac_sclk   (dac_sclk),
`ifdef DDS_DAC_SPI_LDAC_EN
        .dac_ldac_n (dac_ldac_n),
`endif
        .dac_mosi   (dac_mosi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    int          cyc = 0;
    int          last_acc = 0;
    bit          have_acc = 0;
    bit          b2b = 0;
    int          mon_bits = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // SPI frame monitor: captures MOSI on SCLK rising edges while cs_n is low
    initial begin
        bit          prev_cs = 1'b1;
        bit          prev_sclk = 1'b0;
        bit          have_prev = 1'b0;
        int          low_cnt = 0;
        int          high_cnt = 0;
        logic [15:0] cap = '0;
        logic [15:0] exp_f;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_bits = 0; low_cnt = 0; high_cnt = 0;
                have_prev = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b0;
                continue;
            end
`ifdef DDS_DAC_SPI_LDAC_EN
            chk("ldac_n", dac_ldac_n, !(!prev_cs && dac_cs_n));
`endif
            if (prev_cs && !dac_cs_n) begin
                if (have_prev && b2b) chk("cs_high_gap", high_cnt, CS_GAP);
                low_cnt = 1; mon_bits = 0; cap = '0;
            end else if (!dac_cs_n) begin
                low_cnt++;
            end else if (!prev_cs) begin
                chk("frame_bits", mon_bits, 16);
                chk("cs_low_clks", low_cnt, c_LOW);
                if (sb.size() == 0) begin
                    fail_now("sb_unexpected_frame");
                end else begin
                    exp_f = sb.pop_front();
                    chk("frame_data", cap, exp_f);
                end
                have_prev = 1'b1; high_cnt = 1;
            end else begin
                high_cnt++;
            end
            if (!dac_cs_n && dac_sclk && !prev_sclk) begin
                cap = {cap[14:0], dac_mosi};
                mon_bits++;
            end
            prev_cs = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    task automatic send(input logic [7:0] d, input logic [15:0] exp, input bit push, input bit disturb);
        int t;
        @(negedge clk);
        din = d;
        din_vld = 1'b1;
        if (push) sb.push_back(exp);
        t = 0;
        while (!din_rdy && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!din_rdy) begin
            fail_now("accept_timeout");
            return;
        end
        @(posedge clk);
        if (have_acc) chk("accept_spacing", cyc - last_acc, c_SPACE);
        last_acc = cyc;
        have_acc = 1'b1;
        @(negedge clk);
        chk("busy_in_frame", busy, 1'b1);
        chk("rdy_after_accept", din_rdy, 1'b0);
        if (disturb) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                din = 8'($urandom);
                din_vld = 1'($urandom_range(0, 1));
                chk("rdy_midframe", din_rdy, 1'b0);
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] frame;
        bit          disturb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hA5, 16'h3A50, 1'b0};
        vecs[1] = '{8'h00, 16'h3000, 1'b0};
        vecs[2] = '{8'hFF, 16'h3FF0, 1'b1};
        vecs[3] = '{8'h5A, 16'h35A0, 1'b0};
        vecs[4] = '{8'h81, 16'h3810, 1'b0};

        rst_n = 1'b0;
        din = 8'h00;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", din_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cs_n", dac_cs_n, 1'b1);
        chk("rst_sclk", dac_sclk, 1'b0);
        chk("rst_mosi", dac_mosi, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", din_rdy, 1'b1);
        chk("idle_cs_n", dac_cs_n, 1'b1);
        chk("idle_sclk", dac_sclk, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // back-to-back frames with din_vld held high
        b2b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].d, vecs[i].frame, 1'b1, vecs[i].disturb);
        end
        @(negedge clk);
        din_vld = 1'b0;
        drain();
        b2b = 1'b0;
        have_acc = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_rdy_again", din_rdy, 1'b1);

        // abort a frame with reset around SCLK edge 7
        send(8'hC3, 16'h0000, 1'b0, 1'b0);
        begin
            int t = 0;
            while (mon_bits < 4 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (mon_bits < 4) fail_now("abort_wait");
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", dac_cs_n, 1'b1);
        chk("abort_sclk", dac_sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdy", din_rdy, 1'b0);
        repeat (2) @(negedge clk);
        din_vld = 1'b0;
        rst_n = 1'b1;
        have_acc = 1'b0;
        send(8'h3C, 16'h33C0, 1'b1, 1'b0);
        @(negedge clk);
        din_vld = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
